add_serial: RTL and testbench
=============================

Name: add_serial

Overview:
Bit-serial add/subtract sequencer that sits directly upstream of the add1 full-adder cell. It captures two WIDTH-bit operands and feeds one bit pair per cycle, LSB first, into a single add1 instance. It keeps the carry in a flip-flop between cycles and shifts each sum bit into a result register. It trades latency for area in the ALU datapath and uses a start/busy/done handshake.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled on rising clk edge
sub  input  1  0 = a+b, 1 = a-b; captured with start
a  input  WIDTH  operand A, captured with start
b  input  WIDTH  operand B, captured with start
busy  output  1  high while bits are being processed
done  output  1  single-cycle pulse; result valid from this cycle
sum  output  WIDTH  result; held stable from done until the next accepted start
carry_out  output  1  raw carry out of MSB (for subtract: 1 = no borrow)
overflow  output  1  two's-complement signed overflow
zero  output  1  1 when sum == 0

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy, done, carry_out, overflow = 0; sum = 0; zero = 1; internal shift registers, carry flop and bit counter = 0.
- Release of reset is synchronous to clk. First start can be accepted on the first edge after rst_n goes high.
- State IDLE: busy = 0, done = 0.
  - start = 1 at an edge -> load a into shift reg A.
  - Load b into shift reg B, or ~b when sub = 1.
  - carry flop = sub; counter = 0; go to RUN.
- State RUN: busy = 1.
  - Each edge: add1 inputs are A[0], B[0] and the carry flop.
  - add1 out is shifted into the sum register MSB side, so after WIDTH shifts bit 0 is the LSB.
  - carry flop takes add1 carry_out; A and B shift right; counter increments.
  - On the edge where counter == WIDTH-1 (the WIDTH-th bit):
    - capture carry_out from add1;
    - overflow = carry into MSB XOR carry out of MSB;
    - update sum and zero;
    - go to DONE.
- State DONE: done = 1 for exactly one cycle, busy = 0.
  - start = 1 at this edge is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0. busy is high for edges E1..EWIDTH. done is high in the cycle following EWIDTH, i.e. WIDTH+1 edges after start is sampled.
- start while busy = 1 is ignored: no reload, operands unaffected.
- a, b and sub may change freely after the accepting edge.
- sum, carry_out, overflow and zero are registered outputs.
  - They update only on the final RUN edge.
  - They hold their previous values throughout RUN (no partial results visible), and in IDLE.
- zero is computed on the final result, not on intermediate shift contents.
- Widths: sum is modulo 2^WIDTH, with no sign extension. sub uses two's complement (invert b, carry-in 1).
- Reset asserted mid-RUN aborts immediately to reset values; no done pulse is produced for the aborted operation.
- Per-bit sum and carry must come from an add1 instance, not from a behavioural '+'.

Test Plan:
1. Reset then idle: rst_n low -> busy=0, done=0, sum=0, zero=1. Hold start=0 for 10 cycles -> no change.
2. Add with wrap: WIDTH=4, a=7, b=9, sub=0 -> busy high 4 cycles, then done 1 cycle; sum=0, carry_out=1, zero=1, overflow=0.
3. Subtract: a=5, b=3, sub=1 -> sum=2, carry_out=1, overflow=0. Then a=3, b=5, sub=1 -> sum=14, carry_out=0, zero=0.
4. Signed overflow: a=7, b=1, sub=0 -> sum=8, overflow=1, carry_out=0. Also a=8, b=1, sub=1 -> sum=7, overflow=1.
5. Handshake abuse:
   - start pulsed again mid-RUN with different operands -> ignored, original result delivered on schedule.
   - start held high in the done cycle -> next op begins with no IDLE gap; busy rises on the following cycle.
6. Reset mid-operation: assert rst_n low on 2nd RUN cycle -> outputs return to reset values at once, no done pulse. After release, a=2, b=2 -> sum=4 with normal latency.

Source files
------------

// File: rtl/add_serial_if.sv
// Operand/result bundle for the bit-serial add/subtract sequencer.
// The master side issues operations, the slave side (add_serial) answers them.
interface add_serial_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry_out, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry_out, overflow, zero
    );
endinterface

// File: rtl/add_serial.sv
// Bit-serial add/subtract sequencer: one add1 full-adder cell processes one
// bit pair per cycle, LSB first, with the carry held in a flop between bits.

// Single-bit full adder cell that the sequencer reuses on every cycle.
module add1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ cin;
    assign carry_out = (a & b) | (a & cin) | (b & cin);
endmodule

module add_serial #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    add_serial_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             bit_sum;
    logic             bit_carry;

    // The only arithmetic in the block: current LSBs plus the stored carry.
    add1 u_add1 (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .cin       (carry_q),
        .sum       (bit_sum),
        .carry_out (bit_carry)
    );

    // Sequencer: load on start, shift one bit per RUN cycle, publish results on the last bit.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = {bit_sum, acc_q[WIDTH-1:1]};
                carry_d = bit_carry;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = acc_d;
                    cout_d  = bit_carry;
                    ovf_d   = carry_q ^ bit_carry;
                    zero_d  = ~|acc_d;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_add_serial.sv
// Scoreboard bench for add_serial: stimulus pushes hand-computed results,
// an independent monitor pops and checks them whenever done is presented.
module tb_add_serial;
    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        int               done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic [WIDTH-1:0] held_sum = '0;

    add_serial_if #(.WIDTH(WIDTH)) bus ();

    add_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock and an edge counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Issue one operation and queue its expected result; returns just after the accepting edge.
    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sub, input logic [WIDTH-1:0] esum,
                                  input logic ecout, input logic eovf, input logic ezero);
        exp_t e;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        e.sum      = esum;
        e.cout     = ecout;
        e.ovf      = eovf;
        e.zero     = ezero;
        e.done_cyc = cyc + WIDTH;
        sb.push_back(e);
    endtask

    // Bounded wait for the done pulse; returns at the negedge where done is seen.
    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected done", budget);
    endtask

    // Monitor: checks every done against the scoreboard and that sum never moves while busy.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected done=0 (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check_output("sum", int'(bus.sum), int'(e.sum));
                    check_output("carry_out", int'(bus.carry_out), int'(e.cout));
                    check_output("overflow", int'(bus.overflow), int'(e.ovf));
                    check_output("zero", int'(bus.zero), int'(e.zero));
                    check_output("done_cycle", cyc, e.done_cyc);
                    check_output("busy_in_done", int'(bus.busy), 0);
                    held_sum = e.sum;
                end
            end else if (bus.busy) begin
                check_output("sum_hold", int'(bus.sum), int'(held_sum));
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        #12;
        check_output("rst_busy", int'(bus.busy), 0);
        check_output("rst_done", int'(bus.done), 0);
        check_output("rst_sum", int'(bus.sum), 0);
        check_output("rst_zero", int'(bus.zero), 1);
        check_output("rst_carry_out", int'(bus.carry_out), 0);
        check_output("rst_overflow", int'(bus.overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with start low: nothing moves
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("idle_busy", int'(bus.busy), 0);
            check_output("idle_done", int'(bus.done), 0);
        end
        check_output("idle_sum", int'(bus.sum), 0);
        check_output("idle_zero", int'(bus.zero), 1);

        // Directed vectors: a, b, sub -> sum, carry_out, overflow, zero
        apply_stimulus(4'd7, 4'd9, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        check_output("busy_after_start", int'(bus.busy), 1);
        wait_done(20);
        @(negedge clk);
        apply_stimulus(4'd5, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        wait_done(20);
        @(negedge clk);
        apply_stimulus(4'd3, 4'd5, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        wait_done(20);
        @(negedge clk);
        apply_stimulus(4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
        wait_done(20);
        @(negedge clk);
        apply_stimulus(4'd8, 4'd1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
        wait_done(20);
        @(negedge clk);
        apply_stimulus(4'd12, 4'd12, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        wait_done(20);
        @(negedge clk);

        // Start pulsed mid-RUN with other operands must be ignored
        apply_stimulus(4'd6, 4'd5, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.a     = 4'd1;
        bus.b     = 4'd1;
        bus.sub   = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(20);
        @(negedge clk);

        // Back-to-back: start held in the done cycle begins the next op without an IDLE gap
        apply_stimulus(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        wait_done(20);
        apply_stimulus(4'd4, 4'd6, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        check_output("busy_b2b", int'(bus.busy), 1);
        wait_done(20);
        @(negedge clk);

        // Reset asserted in the second RUN cycle aborts with no done pulse
        apply_stimulus(4'd3, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        held_sum = '0;
        check_output("abort_busy", int'(bus.busy), 0);
        check_output("abort_done", int'(bus.done), 0);
        check_output("abort_sum", int'(bus.sum), 0);
        check_output("abort_zero", int'(bus.zero), 1);
        check_output("abort_carry_out", int'(bus.carry_out), 0);
        check_output("abort_overflow", int'(bus.overflow), 0);
        repeat (3) @(negedge clk);
        check_output("abort_hold_done", int'(bus.done), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("post_abort_done", int'(bus.done), 0);
        end
        apply_stimulus(4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
        wait_done(20);

        // Drain: every queued result must have been seen
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check_output("scoreboard_empty", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
